stepmotor_phase_monitor: RTL and testbench
==========================================

Name: stepmotor_phase_monitor

Overview:
- Receive-side companion to the step-motor controller: samples the 4-bit coil drive pattern the controller produces.
- Decodes each phase transition into a direction and a step event, and keeps a signed position count.
- Flags skipped or illegal phase patterns and detects stall (no steps for a programmable time).
- Sits beside the controller on the same clock; its outputs feed the display/LED logic and the self-check bench.

Parameters:
POS_W, 16, width of signed position counter (two's complement, wraps)
STALL_CYCLES, 8, idle clocks without a step before stalled asserts (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
stepmotor  input  4  coil pattern from the controller, sampled on every rising clk edge
clr  input  1  synchronous clear of position and error flags
position  output  POS_W  signed step count, +1 per CW step, -1 per CCW step
dir  output  2  00 idle/stalled, 01 CW, 10 CCW (11 never driven)
step_pulse  output  1  one-clock pulse per accepted step
stalled  output  1  high while idle count has reached STALL_CYCLES
err_skip  output  1  sticky: a two-phase jump was seen
err_illegal  output  1  sticky: a non-one-hot pattern was seen

Behaviour:
- Phase index: 0001->0, 0010->1, 0100->2, 1000->3. Any other pattern (0000, multi-hot) is illegal.
- Internal state: ref_idx[1:0], have_ref, idle_cnt (0..STALL_CYCLES saturating).
- Reset (async, rst=1): position=0, dir=00, step_pulse=0, stalled=0, err_skip=0, err_illegal=0, have_ref=0, ref_idx=0, idle_cnt=0.
- Each rising edge, with delta = (idx - ref_idx) mod 4 for the sampled pattern:
  - Illegal pattern: err_illegal<=1; ref_idx, have_ref and position unchanged; no step.
  - Legal, have_ref=0: ref_idx<=idx, have_ref<=1; no step (first pattern after reset only latches).
  - delta=0: no step.
  - delta=1: CW step. position+1, dir<=01, step_pulse<=1, ref_idx<=idx.
  - delta=3: CCW step. position-1, dir<=10, step_pulse<=1, ref_idx<=idx.
  - delta=2: skip. err_skip<=1, ref_idx<=idx, position unchanged, no pulse, dir unchanged.
- step_pulse is high for exactly the one cycle after the edge that accepted the step. Latency from sampled pattern change to position/dir/step_pulse update: 1 edge.
- Stall tracking:
  - idle_cnt clears to 0 on a step edge; otherwise it increments, saturating at STALL_CYCLES.
  - stalled = (idle_cnt == STALL_CYCLES), registered.
  - When stalled goes high, dir<=00 on the same edge.
  - The next step clears stalled and sets dir at that edge.
- Position arithmetic: POS_W-bit two's complement, wraps silently (max+1 -> min, min-1 -> max).
- clr=1:
  - position<=0, err_skip<=0, err_illegal<=0.
  - ref_idx/have_ref update normally, so the phase reference is never lost.
  - If a step is decoded in the same cycle: clr wins for position (0), but step_pulse and dir still reflect the step.
  - If an error is decoded in the same cycle: clr wins and the flag stays 0.
- Reset mid-sequence clears everything immediately. The first legal pattern after release only re-latches the reference and never counts.

Test Plan:
1. Reset, then hold 0001 for 10 clocks -> position=0, no step_pulse, dir=00, stalled=1 from the 8th edge on.
2. From 0001, apply 0010,0100,1000,0001 one per clock -> 4 step_pulses, position=4, dir=01, stalled=0; hold 0001 for 8 clocks -> stalled=1, dir=00.
3. From reference 0001, apply 1000,0100,0010 -> position=16'hFFFD (-3), dir=10, 3 pulses.
4. Reference 0001, apply 0100 -> err_skip=1, position unchanged, no pulse; then 1000 -> position+1; pulse clr -> err_skip=0, position=0.
5. Reference 0001, apply 0000 then 0011 -> err_illegal=1, no pulse; then 0010 -> counts +1 (reference retained).
6. POS_W=4: 8 CW steps from 0 -> position 7 then 4'b1000 (-8). Assert rst mid-sequence -> all outputs 0 at once; next pattern after release gives no pulse.

Source files
------------

// File: rtl/stepmotor_phase_monitor_if.sv
// Bundle between the phase monitor and its consumer: the sampled coil pattern
// and clear go in, decoded position, direction and status flags come out.
interface stepmotor_phase_monitor_if #(
    parameter int POS_W = 16
);
    logic [3:0]       stepmotor;
    logic             clr;
    logic [POS_W-1:0] position;
    logic [1:0]       dir;
    logic             step_pulse;
    logic             stalled;
    logic             err_skip;
    logic             err_illegal;

    modport master (
        output stepmotor, clr,
        input  position, dir, step_pulse, stalled, err_skip, err_illegal
    );

    modport slave (
        input  stepmotor, clr,
        output position, dir, step_pulse, stalled, err_skip, err_illegal
    );
endinterface

// File: rtl/stepmotor_phase_monitor.sv
// Decodes the controller's one-hot coil pattern into step events, a signed
// position count, direction, stall detection and sticky skip/illegal flags.
module stepmotor_phase_monitor #(
    parameter int POS_W        = 16,
    parameter int STALL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    stepmotor_phase_monitor_if.slave bus
);
    localparam int CNT_W = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

    logic [1:0]       ref_idx;
    logic             have_ref;
    logic [CNT_W-1:0] idle_cnt;

    logic [POS_W-1:0] position;
    logic [1:0]       dir;
    logic             step_pulse;
    logic             stalled;
    logic             err_skip;
    logic             err_illegal;

    logic             legal;
    logic [1:0]       idx;
    logic [1:0]       delta;
    logic             step_cw;
    logic             step_ccw;
    logic             skip;
    logic [CNT_W-1:0] idle_next;

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        unique case (bus.stepmotor)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: legal = 1'b0;
        endcase
        // 2-bit subtraction gives the modulo-4 phase distance directly
        delta    = idx - ref_idx;
        step_cw  = legal && have_ref && (delta == 2'd1);
        step_ccw = legal && have_ref && (delta == 2'd3);
        skip     = legal && have_ref && (delta == 2'd2);
        if (step_cw || step_ccw)
            idle_next = '0;
        else if (idle_cnt == STALL_MAX)
            idle_next = idle_cnt;
        else
            idle_next = idle_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_idx     <= 2'd0;
            have_ref    <= 1'b0;
            idle_cnt    <= '0;
            position    <= '0;
            dir         <= 2'b00;
            step_pulse  <= 1'b0;
            stalled     <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            // Reference tracks every legal pattern, even under clr
            if (legal) begin
                ref_idx  <= idx;
                have_ref <= 1'b1;
            end

            step_pulse <= step_cw || step_ccw;
            idle_cnt   <= idle_next;
            stalled    <= (idle_next == STALL_MAX);

            if (step_cw)
                dir <= 2'b01;
            else if (step_ccw)
                dir <= 2'b10;
            else if ((idle_next == STALL_MAX) && !stalled)
                dir <= 2'b00;

            if (bus.clr)
                position <= '0;
            else if (step_cw)
                position <= position + POS_W'(1);
            else if (step_ccw)
                position <= position - POS_W'(1);

            if (bus.clr)
                err_skip <= 1'b0;
            else if (skip)
                err_skip <= 1'b1;

            if (bus.clr)
                err_illegal <= 1'b0;
            else if (!legal)
                err_illegal <= 1'b1;
        end
    end

    assign bus.position    = position;
    assign bus.dir         = dir;
    assign bus.step_pulse  = step_pulse;
    assign bus.stalled     = stalled;
    assign bus.err_skip    = err_skip;
    assign bus.err_illegal = err_illegal;
endmodule

// File: tb/tb_stepmotor_phase_monitor.sv
// Bench for stepmotor_phase_monitor: fixed vector table, randomized run against
// a behavioural model, and hand sequences for wrap and mid-sequence reset.
module tb_stepmotor_phase_monitor;
    localparam int STALL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sm  = 4'b0000;
    logic       clr_v = 1'b0;

    int checks   = 0;
    int failures = 0;

    stepmotor_phase_monitor_if #(.POS_W(16)) ifa ();
    stepmotor_phase_monitor_if #(.POS_W(4))  ifb ();

    assign ifa.stepmotor = sm;
    assign ifa.clr       = clr_v;
    assign ifb.stepmotor = sm;
    assign ifb.clr       = clr_v;

    stepmotor_phase_monitor #(.POS_W(16), .STALL_CYCLES(STALL)) dut (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    stepmotor_phase_monitor #(.POS_W(4), .STALL_CYCLES(STALL)) dut4 (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase as an integer 0..3, position as an unbounded int
    bit m_have;
    int m_ref, m_pos, m_idle, m_dir;
    bit m_pulse, m_stall, m_skip, m_ill;

    task automatic model_reset();
        m_have = 0; m_ref = 0; m_pos = 0; m_idle = 0; m_dir = 0;
        m_pulse = 0; m_stall = 0; m_skip = 0; m_ill = 0;
    endtask

    task automatic model_edge(input logic [3:0] p, input logic c);
        int ph, d;
        bit stepped;
        stepped = 0;
        m_pulse = 0;
        ph = 0;
        for (int i = 0; i < 4; i++) if (p[i]) ph = i;
        if ($countones(p) != 1) begin
            m_ill = 1;
        end else if (!m_have) begin
            m_have = 1;
            m_ref  = ph;
        end else begin
            d = (ph - m_ref + 4) % 4;
            if (d == 1) begin
                m_pos++; m_dir = 1; stepped = 1;
            end else if (d == 3) begin
                m_pos--; m_dir = 2; stepped = 1;
            end else if (d == 2) begin
                m_skip = 1;
            end
            m_ref = ph;
        end
        m_pulse = stepped;
        if (stepped) begin
            m_idle  = 0;
            m_stall = 0;
        end else begin
            if (m_idle < STALL) m_idle++;
            if (m_idle == STALL && !m_stall) m_dir = 0;
            m_stall = (m_idle == STALL);
        end
        if (c) begin
            m_pos = 0; m_skip = 0; m_ill = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] p;
        p = m_pos;
        chk("pos16", {16'h0, ifa.position}, {16'h0, p[15:0]});
        chk("pos4",  {28'h0, ifb.position}, {28'h0, p[3:0]});
        chk("dir",   {30'h0, ifa.dir}, m_dir);
        chk("dir4",  {30'h0, ifb.dir}, m_dir);
        chk("pulse", {31'h0, ifa.step_pulse}, {31'h0, m_pulse});
        chk("stall", {31'h0, ifa.stalled}, {31'h0, m_stall});
        chk("skip",  {31'h0, ifa.err_skip}, {31'h0, m_skip});
        chk("ill",   {31'h0, ifa.err_illegal}, {31'h0, m_ill});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pos"},  {16'h0, ifa.position}, 0);
        chk({tag, "_pos4"}, {28'h0, ifb.position}, 0);
        chk({tag, "_dir"},  {30'h0, ifa.dir}, 0);
        chk({tag, "_flags"}, {28'h0, ifa.step_pulse, ifa.stalled, ifa.err_skip, ifa.err_illegal}, 0);
        chk({tag, "_flags4"}, {28'h0, ifb.step_pulse, ifb.stalled, ifb.err_skip, ifb.err_illegal}, 0);
    endtask

    // One clock: inputs already set away from the edge, model steps with the DUT
    task automatic cyc(input logic [3:0] p, input logic c);
        sm = p;
        clr_v = c;
        @(posedge clk);
        model_edge(p, c);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  pat;
        logic        clr;
        logic [15:0] pos;
        logic [1:0]  dir;
        logic        pulse;
        logic        stl;
        logic        skip;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] pat, input logic c, input logic [15:0] pos,
                       input logic [1:0] d, input logic pu, input logic st,
                       input logic sk, input logic il);
        vec_t v;
        v.pat = pat; v.clr = c; v.pos = pos; v.dir = d;
        v.pulse = pu; v.stl = st; v.skip = sk; v.ill = il;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] p;
        int ph, hold;

        // hold 0001 after reset: latch only, stall from the 8th edge
        for (int k = 1; k <= 10; k++) add(4'b0001, 0, 16'h0, 2'b00, 0, k >= 8, 0, 0);
        // four CW steps, then idle into stall
        add(4'b0010, 0, 16'd1, 2'b01, 1, 0, 0, 0);
        add(4'b0100, 0, 16'd2, 2'b01, 1, 0, 0, 0);
        add(4'b1000, 0, 16'd3, 2'b01, 1, 0, 0, 0);
        add(4'b0001, 0, 16'd4, 2'b01, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(4'b0001, 0, 16'd4, (k < 8) ? 2'b01 : 2'b00, 0, k == 8, 0, 0);
        // clear, then three CCW steps to -3
        add(4'b0001, 1, 16'h0,    2'b00, 0, 1, 0, 0);
        add(4'b1000, 0, 16'hFFFF, 2'b10, 1, 0, 0, 0);
        add(4'b0100, 0, 16'hFFFE, 2'b10, 1, 0, 0, 0);
        add(4'b0010, 0, 16'hFFFD, 2'b10, 1, 0, 0, 0);
        // skip error and its clear
        add(4'b0001, 0, 16'hFFFC, 2'b10, 1, 0, 0, 0);
        add(4'b0001, 1, 16'h0,    2'b10, 0, 0, 0, 0);
        add(4'b0100, 0, 16'h0,    2'b10, 0, 0, 1, 0);
        add(4'b1000, 0, 16'd1,    2'b01, 1, 0, 1, 0);
        add(4'b1000, 1, 16'h0,    2'b01, 0, 0, 0, 0);
        // illegal patterns keep the reference; clr against step and errors
        add(4'b0001, 0, 16'd1, 2'b01, 1, 0, 0, 0);
        add(4'b0000, 0, 16'd1, 2'b01, 0, 0, 0, 1);
        add(4'b0011, 0, 16'd1, 2'b01, 0, 0, 0, 1);
        add(4'b0010, 0, 16'd2, 2'b01, 1, 0, 0, 1);
        add(4'b0100, 1, 16'h0, 2'b01, 1, 0, 0, 0);
        add(4'b0101, 1, 16'h0, 2'b01, 0, 0, 0, 0);
        add(4'b0001, 1, 16'h0, 2'b01, 0, 0, 0, 0);
        add(4'b0100, 0, 16'h0, 2'b01, 0, 0, 1, 0);

        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].pat, tbl[i].clr);
            chk($sformatf("v%0d_pos", i), {16'h0, ifa.position}, {16'h0, tbl[i].pos});
            chk($sformatf("v%0d_dir", i), {30'h0, ifa.dir}, {30'h0, tbl[i].dir});
            chk($sformatf("v%0d_flags", i),
                {28'h0, ifa.step_pulse, ifa.stalled, ifa.err_skip, ifa.err_illegal},
                {28'h0, tbl[i].pulse, tbl[i].stl, tbl[i].skip, tbl[i].ill});
        end

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            ph = m_ref;
            case ($urandom_range(0, 19))
                0, 1: begin
                    hold = $urandom_range(1, 12);
                    for (int h = 0; h < hold; h++) begin
                        cyc(4'(1 << ph), 1'b0);
                        check_model();
                    end
                    continue;
                end
                2:       p = 4'($urandom_range(0, 15));
                3:       p = 4'(1 << ((ph + 2) % 4));
                default: p = 4'(1 << (($urandom_range(0, 1) != 0) ? (ph + 1) % 4 : (ph + 3) % 4));
            endcase
            cyc(p, $urandom_range(0, 19) == 0);
            check_model();
        end

        // 4-bit wrap: +7 then -8
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0001, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(4'(1 << (k % 4)), 0);
            check_model();
            if (k == 7) chk("wrap7", {28'h0, ifb.position}, 32'h7);
            if (k == 8) chk("wrap8", {28'h0, ifb.position}, 32'h8);
        end
        cyc(4'b0010, 0);
        cyc(4'b0100, 0);

        // reset mid-sequence takes effect without a clock edge
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(4'b1000, 0);
        chk("relatch_pulse", {31'h0, ifa.step_pulse}, 0);
        chk("relatch_pos", {16'h0, ifa.position}, 0);
        check_model();
        cyc(4'b0001, 0);
        chk("after_relatch_pos", {16'h0, ifa.position}, 1);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
